enc_seg_thresh: RTL and testbench

ENC_SEG_THRESH -- requirements
Module: enc_seg_thresh

---
 rtl/enc_seg_thresh.sv | 151 +++++++++++++++
 tb/tb_enc_seg_thresh.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_seg_thresh.sv
// Thresholded bundling encoder: popcounts each feature column of four 1024-dim segments, compares against a latched threshold.
// Latency: done in cycle T+5 after start at edge T (T+6 with ENC_THRESH_PIPE_EN). Backpressure: none; start accepted only in IDLE.
// Optional macro ENC_THRESH_PIPE_EN registers the popcounts and adds a DRAIN state.
module enc_seg_thresh #(
    parameter int FEATURE_COUNT = 617,
    parameter int HV_DIM        = 4096,
    parameter int DIMS_PER_CC   = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [9:0]                             thr,
    output logic [1:0]                             ctr,
    input  logic [DIMS_PER_CC*FEATURE_COUNT-1:0]   seg_in,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   hv_valid,
    output logic [HV_DIM-1:0]                      hv_out
);
    localparam int NSEG = HV_DIM / DIMS_PER_CC;

`ifdef ENC_THRESH_PIPE_EN
    typedef enum logic [1:0] {IDLE, SEG, DRAIN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEG, DONE} state_t;
`endif

    state_t                  state_q;
    logic [1:0]              ctr_q;
    logic [9:0]              thr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    hv_valid_q;
    logic [HV_DIM-1:0]       hv_out_q;

    logic [9:0]              pc_d [DIMS_PER_CC];
    logic [DIMS_PER_CC-1:0]  bits_d;
    logic                    wr_en_d;
    logic [1:0]              wr_seg_d;

`ifdef ENC_THRESH_PIPE_EN
    logic [9:0]              pc_q [DIMS_PER_CC];
    logic [1:0]              seg_q;
    logic                    pv_q;
`endif

    always_comb begin
        for (int j = 0; j < DIMS_PER_CC; j++) begin
            pc_d[j] = 10'($countones(seg_in[j*FEATURE_COUNT +: FEATURE_COUNT]));
        end
    end

    // The segment write either follows ctr directly or lags it by one cycle through the popcount register.
    always_comb begin
        bits_d = '0;
`ifdef ENC_THRESH_PIPE_EN
        wr_en_d  = pv_q;
        wr_seg_d = seg_q;
        for (int j = 0; j < DIMS_PER_CC; j++) begin
            bits_d[j] = (pc_q[j] > thr_q);
        end
`else
        wr_en_d  = (state_q == SEG);
        wr_seg_d = ctr_q;
        for (int j = 0; j < DIMS_PER_CC; j++) begin
            bits_d[j] = (pc_d[j] > thr_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctr_q      <= 2'd0;
            thr_q      <= 10'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hv_valid_q <= 1'b0;
            hv_out_q   <= '0;
`ifdef ENC_THRESH_PIPE_EN
            seg_q      <= 2'd0;
            pv_q       <= 1'b0;
            for (int j = 0; j < DIMS_PER_CC; j++) begin
                pc_q[j] <= 10'd0;
            end
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ENC_THRESH_PIPE_EN
            pv_q   <= 1'b0;
`endif
            for (int k = 0; k < NSEG; k++) begin
                if (wr_en_d && (wr_seg_d == 2'(k))) begin
                    hv_out_q[k*DIMS_PER_CC +: DIMS_PER_CC] <= bits_d;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SEG;
                        ctr_q      <= 2'd0;
                        thr_q      <= thr;
                        busy_q     <= 1'b1;
                        hv_valid_q <= 1'b0;
                    end
                end
                SEG: begin
`ifdef ENC_THRESH_PIPE_EN
                    pc_q  <= pc_d;
                    seg_q <= ctr_q;
                    pv_q  <= 1'b1;
`endif
                    if (ctr_q == 2'(NSEG - 1)) begin
                        ctr_q <= 2'd0;
`ifdef ENC_THRESH_PIPE_EN
                        state_q <= DRAIN;
`else
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        hv_valid_q <= 1'b1;
`endif
                    end else begin
                        ctr_q <= ctr_q + 2'd1;
                    end
                end
`ifdef ENC_THRESH_PIPE_EN
                DRAIN: begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    hv_valid_q <= 1'b1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ctr_q   <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctr      = ctr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hv_valid = hv_valid_q;
    assign hv_out   = hv_out_q;
endmodule

// File: tb/tb_enc_seg_thresh.sv
// Bench for enc_seg_thresh: job-level reference model plus directed literal checks and randomized jobs.
module tb_enc_seg_thresh;
    localparam int F  = 617;
    localparam int D  = 1024;
    localparam int HV = 4096;
    localparam int NS = 4;
    localparam int W  = ((F + 31) / 32) * 32;
`ifdef ENC_THRESH_PIPE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [9:0]      thr;
    logic [1:0]      ctr;
    logic [D*F-1:0]  seg_in;
    logic            busy, done, hv_valid;
    logic [HV-1:0]   hv_out;

    logic [D*F-1:0]  seg_pat [NS];

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int cyc      = 0;

    // reference model state: age = cycles since the accepted start edge (0 = idle)
    int              age     = 0;
    logic            m_valid = 1'b0;
    logic [HV-1:0]   m_hv    = '0;
    logic            live    = 1'b0;

    enc_seg_thresh dut (
        .clk(clk), .rst(rst), .start(start), .thr(thr), .ctr(ctr),
        .seg_in(seg_in), .busy(busy), .done(done), .hv_valid(hv_valid), .hv_out(hv_out)
    );

    always #5 clk = ~clk;

    assign seg_in = seg_pat[ctr];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_hv(input string nm, input logic [HV-1:0] got, input logic [HV-1:0] exp);
        int nd, first;
        nd = 0;
        first = -1;
        for (int i = 0; i < HV; i++) begin
            if (got[i] !== exp[i]) begin
                nd++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nd != 0) begin
            n_errors++;
            $display("FAIL %s: %0d bits differ, first at bit %0d (got %b expected %b) at %0t",
                     nm, nd, first, got[first], exp[first], $time);
        end
    endtask

    function automatic logic [HV-1:0] model_hv(input logic [9:0] t);
        logic [HV-1:0] r;
        logic [F-1:0]  col;
        r = '0;
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < D; j++) begin
                col = seg_pat[k][j*F +: F];
                r[k*D + j] = ($countones(col) > int'(t));
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            live    <= 1'b1;
            age     <= 0;
            m_valid <= 1'b0;
        end else if (age == 0) begin
            if (start) begin
                age     <= 1;
                m_hv    <= model_hv(thr);
                m_valid <= 1'b0;
            end
        end else begin
            age <= (age == LAT) ? 0 : age + 1;
            if (age + 1 == LAT) m_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy", 32'(busy), 32'(age >= 1 && age <= LAT));
            chk("done", 32'(done), 32'(age == LAT));
            chk("hv_valid", 32'(hv_valid), 32'(m_valid));
            chk("ctr", 32'(ctr), (age >= 1 && age <= NS) ? 32'(age - 1) : 32'd0);
            if (m_valid) chk_hv("hv_out_model", hv_out, m_hv);
            if (done === 1'b1) n_done++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [F-1:0] cnt_col(input int c);
        logic [F-1:0] o;
        o = '1;
        if (c <= 0) return '0;
        if (c >= F) return o;
        o = o >> (F - c);
        return o << $urandom_range(0, F - c);
    endfunction

    task automatic fill_count(input int k, input int c);
        for (int j = 0; j < D; j++) seg_pat[k][j*F +: F] = cnt_col(c);
    endtask

    task automatic fill_rand(input int k, input int t);
        logic [W-1:0] w;
        int r, c;
        for (int j = 0; j < D; j++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                seg_pat[k][j*F +: F] = '0;
            end else if (r == 1) begin
                seg_pat[k][j*F +: F] = '1;
            end else if (r <= 5) begin
                for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
                seg_pat[k][j*F +: F] = w[F-1:0];
            end else begin
                c = t + $urandom_range(0, 6) - 3;
                seg_pat[k][j*F +: F] = cnt_col(c);
            end
        end
    endtask

    // Returns with the bench sitting at the negedge of the done cycle.
    task automatic wait_done(input string nm, output int t_done);
        bit seen;
        seen = 1'b0;
        t_done = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                t_done = cyc;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: no done pulse within 20 cycles at %0t", nm, $time);
        end
    endtask

    // Pulses start with threshold t, then scrambles thr; returns the acceptance edge index.
    task automatic launch(input int t, output int t_acc);
        thr   = 10'(t);
        start = 1'b1;
        tick();
        t_acc = cyc - 1;
        start = 1'b0;
        thr   = 10'($urandom_range(0, 1023));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, td, nd0, t, act;
        rst   = 1'b1;
        start = 1'b0;
        thr   = 10'd0;
        for (int k = 0; k < NS; k++) seg_pat[k] = '0;
        tick();
        tick();
        @(negedge clk);
        chk_hv("reset_hv", hv_out, '0);
        chk("reset_ctr", 32'(ctr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;

        // reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; thr = 10'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        tick();

        // all ones, thr=308
        for (int k = 0; k < NS; k++) fill_count(k, F);
        launch(308, ta);
        wait_done("ones_done", td);
        chk("ones_latency", 32'(td - ta), 32'(LAT));
        chk_hv("ones_hv", hv_out, {HV{1'b1}});
        chk("ones_valid", 32'(hv_valid), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("valid_holds", 32'(hv_valid), 32'd1);
        tick();

        // all zeros, thr=0
        for (int k = 0; k < NS; k++) fill_count(k, 0);
        launch(0, ta);
        wait_done("zeros_done", td);
        chk_hv("zeros_hv", hv_out, {HV{1'b0}});
        tick();

        // exactly 309 ones per column at the threshold boundary
        for (int k = 0; k < NS; k++) fill_count(k, 309);
        launch(308, ta);
        wait_done("c309_t308_done", td);
        chk_hv("c309_t308_hv", hv_out, {HV{1'b1}});
        tick();
        launch(309, ta);
        wait_done("c309_t309_done", td);
        chk_hv("c309_t309_hv", hv_out, {HV{1'b0}});
        tick();

        // per-segment counts 400/100/400/100
        for (int k = 0; k < NS; k++) fill_count(k, (k % 2 == 0) ? 400 : 100);
        launch(308, ta);
        wait_done("alt_done", td);
        chk_hv("alt_hv", hv_out, {{D{1'b0}}, {D{1'b1}}, {D{1'b0}}, {D{1'b1}}});
        tick();

        // reset in the second SEG cycle, restart on the first post-reset cycle
        for (int k = 0; k < NS; k++) fill_count(k, F);
        launch(308, ta);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        thr = 10'd308;
        start = 1'b1;
        @(negedge clk);
        chk_hv("abort_hv", hv_out, {HV{1'b0}});
        chk("abort_ctr", 32'(ctr), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        wait_done("restart_done", td);
        chk_hv("restart_hv", hv_out, {HV{1'b1}});
        tick();

        // start with thr=0 during SEG is ignored
        for (int k = 0; k < NS; k++) fill_count(k, 100);
        nd0 = n_done;
        launch(308, ta);
        tick();
        thr = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_done", td);
        chk_hv("ignore_hv", hv_out, {HV{1'b0}});
        tick();
        tick();
        tick();
        chk("ignore_done_count", 32'(n_done - nd0), 32'd1);

        // randomized jobs
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 3))
                0: t = $urandom_range(305, 311);
                1: t = 0;
                2: t = $urandom_range(F, 1023);
                default: t = $urandom_range(0, 1023);
            endcase
            for (int k = 0; k < NS; k++) fill_rand(k, t);
            launch(t, ta);
            act = $urandom_range(0, 4);
            if (act == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                if (act == 1) begin
                    repeat ($urandom_range(0, 2)) tick();
                    thr = 10'd0;
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                wait_done("rand_done", td);
                tick();
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
